// File: rtl/writeback_group_arbiter_if.sv
// Writeback group bundle: issue-side table writes, unit completion requests,
// per-unit grants and the registered commit packet.
interface writeback_group_arbiter_if #(
  parameter int unsigned NUM_UNITS   = 3,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ID_WIDTH    = 3,
  parameter int unsigned PHYS_ADDR_W = 6
);

  logic                            issue_valid;
  logic [ID_WIDTH-1:0]             issue_id;
  logic [PHYS_ADDR_W-1:0]          issue_phys_rd_addr;
  logic [NUM_UNITS-1:0]            unit_done;
  logic [NUM_UNITS*ID_WIDTH-1:0]   unit_id;
  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_data;
  logic [NUM_UNITS-1:0]            unit_ack;
  logic                            commit_valid;
  logic [ID_WIDTH-1:0]             commit_id;
  logic [DATA_WIDTH-1:0]           commit_data;
  logic [PHYS_ADDR_W-1:0]          wb_phys_addr;

  // Issue logic and execution units drive requests; the arbiter answers.
  modport master (
    output issue_valid, issue_id, issue_phys_rd_addr, unit_done, unit_id, unit_data,
    input  unit_ack, commit_valid, commit_id, commit_data, wb_phys_addr
  );

  modport slave (
    input  issue_valid, issue_id, issue_phys_rd_addr, unit_done, unit_id, unit_data,
    output unit_ack, commit_valid, commit_id, commit_data, wb_phys_addr
  );

endinterface

// File: rtl/writeback_group_arbiter.sv
// Round-robin writeback arbiter for one register-file writeback group.
// Grants one completing unit per cycle, looks up its destination physical
// register by instruction ID and registers the commit packet.
module writeback_group_arbiter #(
  parameter int unsigned NUM_UNITS   = 3,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ID_WIDTH    = 3,
  parameter int unsigned PHYS_ADDR_W = 6
) (
  input logic                       clk,
  input logic                       rst,
  writeback_group_arbiter_if.slave  bus
);

  localparam int unsigned PtrW    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int unsigned Entries = 2 ** ID_WIDTH;

  logic [PtrW-1:0]        ptr_q, ptr_d;
  logic [NUM_UNITS-1:0]   ack;
  logic                   gnt_any;
  logic [ID_WIDTH-1:0]    gnt_id;
  logic [DATA_WIDTH-1:0]  gnt_data;

  logic [PHYS_ADDR_W-1:0] id_table [Entries];

  logic                   commit_valid_q;
  logic [ID_WIDTH-1:0]    commit_id_q;
  logic [DATA_WIDTH-1:0]  commit_data_q;
  logic [PHYS_ADDR_W-1:0] wb_phys_addr_q;

  // Rotating priority search: first done unit at or after the pointer wins.
  always_comb begin
    int unsigned idx;
    ack     = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
        if (k == idx && !gnt_any && !rst && bus.unit_done[k]) begin
          gnt_any = 1'b1;
          ack[k]  = 1'b1;
        end
      end
    end
  end

  // One-hot mux of the winner's payload and the pointer advance past it.
  always_comb begin
    gnt_id   = '0;
    gnt_data = '0;
    ptr_d    = ptr_q;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      if (ack[k]) begin
        gnt_id   = bus.unit_id[k*ID_WIDTH +: ID_WIDTH];
        gnt_data = bus.unit_data[k*DATA_WIDTH +: DATA_WIDTH];
        ptr_d    = (k + 1 == NUM_UNITS) ? '0 : PtrW'(k + 1);
      end
    end
  end

  // ID table write; no reset, and writes continue while rst is high.
  always_ff @(posedge clk) begin
    if (bus.issue_valid) id_table[bus.issue_id] <= bus.issue_phys_rd_addr;
  end

  // Commit register and pointer. The table read sees the pre-edge entry,
  // so a same-cycle issue to the granted ID does not leak into this commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q          <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      commit_data_q  <= '0;
      wb_phys_addr_q <= '0;
    end else begin
      ptr_q          <= ptr_d;
      commit_valid_q <= gnt_any;
      if (gnt_any) begin
        commit_id_q    <= gnt_id;
        commit_data_q  <= gnt_data;
        wb_phys_addr_q <= id_table[gnt_id];
      end
    end
  end

  assign bus.unit_ack     = ack;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_id    = commit_id_q;
  assign bus.commit_data  = commit_data_q;
  assign bus.wb_phys_addr = wb_phys_addr_q;

endmodule

// File: tb/tb_writeback_group_arbiter.sv
// Self-checking bench for writeback_group_arbiter: a 3-unit instance driven
// through scenario tasks with a commit scoreboard, plus a 1-unit instance.
module tb_writeback_group_arbiter;

  localparam int unsigned NU = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 3;
  localparam int unsigned AW = 6;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  exp_t          sb[$];
  logic [AW-1:0] tb_table [8];

  writeback_group_arbiter_if #(.NUM_UNITS(NU), .DATA_WIDTH(DW), .ID_WIDTH(IW),
                               .PHYS_ADDR_W(AW)) bus ();
  writeback_group_arbiter_if #(.NUM_UNITS(1), .DATA_WIDTH(DW), .ID_WIDTH(IW),
                               .PHYS_ADDR_W(AW)) bus1 ();

  writeback_group_arbiter #(.NUM_UNITS(NU), .DATA_WIDTH(DW), .ID_WIDTH(IW),
                            .PHYS_ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  writeback_group_arbiter #(.NUM_UNITS(1), .DATA_WIDTH(DW), .ID_WIDTH(IW),
                            .PHYS_ADDR_W(AW)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_unit(input int k, input logic done, input logic [IW-1:0] id,
                          input logic [DW-1:0] data);
    bus.unit_done[k]          = done;
    bus.unit_id[k*IW +: IW]   = id;
    bus.unit_data[k*DW +: DW] = data;
  endtask

  task automatic issue(input logic v, input logic [IW-1:0] id, input logic [AW-1:0] addr);
    bus.issue_valid        = v;
    bus.issue_id           = id;
    bus.issue_phys_rd_addr = addr;
  endtask

  // One clock: check ack mid-cycle, push the expected commit, check after the edge.
  task automatic step(input string name, input logic [NU-1:0] exp_ack);
    exp_t e;
    int   w;
    bit   pushed;
    pushed = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.unit_ack !== exp_ack) begin
      failures++;
      $display("FAIL %s ack: got %b want %b", name, bus.unit_ack, exp_ack);
    end
    w = -1;
    for (int k = 0; k < int'(NU); k++) if (exp_ack[k]) w = k;
    if (w >= 0) begin
      e.id   = bus.unit_id[w*IW +: IW];
      e.data = bus.unit_data[w*DW +: DW];
      e.addr = tb_table[e.id];
      sb.push_back(e);
      pushed = 1'b1;
    end
    if (bus.issue_valid) tb_table[bus.issue_id] = bus.issue_phys_rd_addr;
    @(posedge clk);
    #1;
    checks++;
    if (pushed) begin
      e = sb.pop_front();
      if (bus.commit_valid !== 1'b1 || bus.commit_id !== e.id || bus.commit_data !== e.data ||
          bus.wb_phys_addr !== e.addr) begin
        failures++;
        $display("FAIL %s commit: got v=%b id=%0d data=%h addr=%h want v=1 id=%0d data=%h addr=%h",
                 name, bus.commit_valid, bus.commit_id, bus.commit_data, bus.wb_phys_addr,
                 e.id, e.data, e.addr);
      end
    end else if (bus.commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s commit_valid: got %b want 0", name, bus.commit_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step("reset0", 3'b000);
    step("reset1", 3'b000);
    checks++;
    if (bus.commit_id !== '0 || bus.commit_data !== '0 || bus.wb_phys_addr !== '0) begin
      failures++;
      $display("FAIL reset_fields: got id=%0d data=%h addr=%h want 0 0 0",
               bus.commit_id, bus.commit_data, bus.wb_phys_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_grant;
    issue(1'b1, 3'd2, 6'h15);
    step("sg_issue", 3'b000);
    issue(1'b0, 3'd0, 6'h00);
    set_unit(1, 1'b1, 3'd2, 32'hDEADBEEF);
    step("sg_grant", 3'b010);
    set_unit(1, 1'b0, 3'd0, 32'h0);
    step("sg_idle", 3'b000);
  endtask

  task automatic test_back_to_back;
    issue(1'b1, 3'd0, 6'h01);
    step("rr_iss0", 3'b000);
    issue(1'b1, 3'd1, 6'h02);
    step("rr_iss1", 3'b000);
    issue(1'b1, 3'd3, 6'h03);
    rst = 1'b1;
    step("rr_rst", 3'b000);
    rst = 1'b0;
    issue(1'b0, 3'd0, 6'h00);
    set_unit(0, 1'b1, 3'd0, 32'hA000_0000);
    set_unit(1, 1'b1, 3'd1, 32'hB000_0000);
    set_unit(2, 1'b1, 3'd3, 32'hC000_0000);
    step("rr_0", 3'b001);
    set_unit(0, 1'b1, 3'd0, 32'hA000_0001);
    step("rr_1", 3'b010);
    set_unit(1, 1'b1, 3'd1, 32'hB000_0001);
    step("rr_2", 3'b100);
    set_unit(2, 1'b1, 3'd3, 32'hC000_0001);
    step("rr_3", 3'b001);
  endtask

  // Pointer is at 1 after the last grant to unit 0.
  task automatic test_priority;
    set_unit(0, 1'b1, 3'd1, 32'h1111_0000);
    set_unit(1, 1'b0, 3'd0, 32'h0);
    set_unit(2, 1'b1, 3'd3, 32'h2222_0000);
    step("pri_u2", 3'b100);
    set_unit(2, 1'b0, 3'd0, 32'h0);
    step("pri_u0", 3'b001);
    set_unit(0, 1'b0, 3'd0, 32'h0);
    step("pri_idle", 3'b000);
  endtask

  task automatic test_table_rbw;
    issue(1'b1, 3'd5, 6'h08);
    step("rbw_iss", 3'b000);
    issue(1'b1, 3'd5, 6'h3F);
    set_unit(1, 1'b1, 3'd5, 32'h5555_0001);
    step("rbw_old", 3'b010);
    issue(1'b0, 3'd0, 6'h00);
    set_unit(1, 1'b1, 3'd5, 32'h5555_0002);
    step("rbw_new", 3'b010);
    set_unit(1, 1'b0, 3'd0, 32'h0);
    step("rbw_idle", 3'b000);
  endtask

  task automatic test_reset_mid;
    set_unit(0, 1'b1, 3'd0, 32'h0D0D_0000);
    set_unit(1, 1'b1, 3'd1, 32'h1D1D_0000);
    rst = 1'b1;
    step("rm_rst", 3'b000);
    rst = 1'b0;
    step("rm_u0", 3'b001);
    set_unit(0, 1'b0, 3'd0, 32'h0);
    step("rm_u1", 3'b010);
    set_unit(1, 1'b0, 3'd0, 32'h0);
    step("rm_idle", 3'b000);
  endtask

  // Cycle numbering restarts at 1; done pulses on cycles 3, 4 and 6.
  task automatic test_single_unit;
    logic exp;
    bus1.issue_id           = 3'd0;
    bus1.issue_phys_rd_addr = 6'h2A;
    bus1.unit_id            = 3'd0;
    for (int c = 1; c <= 8; c++) begin
      exp                  = (c == 3 || c == 4 || c == 6);
      bus1.issue_valid     = (c == 1);
      bus1.unit_done       = exp;
      bus1.unit_data       = 32'h1000 + DW'(c);
      @(negedge clk);
      checks++;
      if (bus1.unit_ack !== exp) begin
        failures++;
        $display("FAIL su_ack c=%0d: got %b want %b", c, bus1.unit_ack, exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus1.commit_valid !== exp ||
          (exp && (bus1.commit_data !== 32'h1000 + DW'(c) || bus1.wb_phys_addr !== 6'h2A))) begin
        failures++;
        $display("FAIL su_commit c=%0d: got v=%b data=%h addr=%h want v=%b data=%h addr=2a",
                 c, bus1.commit_valid, bus1.commit_data, bus1.wb_phys_addr, exp,
                 32'h1000 + DW'(c));
      end
    end
    bus1.unit_done = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    issue(1'b0, 3'd0, 6'h00);
    bus.unit_done = '0;
    bus.unit_id   = '0;
    bus.unit_data = '0;
    bus1.issue_valid        = 1'b0;
    bus1.issue_id           = '0;
    bus1.issue_phys_rd_addr = '0;
    bus1.unit_done          = '0;
    bus1.unit_id            = '0;
    bus1.unit_data          = '0;
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_priority();
    test_table_rbw();
    test_reset_mid();
    test_single_unit();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_group_arbiter.md
Name: writeback_group_arbiter

Overview:
- Producer side of the register file's per-group writeback interface.
- For one writeback group, the block:
  - collects completion requests from NUM_UNITS execution units;
  - picks one per cycle by round-robin;
  - looks up the destination physical register by instruction ID;
  - drives a registered commit packet plus physical address one cycle later.
- One instance per writeback group. Its outputs feed the register file's commit and wb_phys_addr inputs.

Parameters:
- NUM_UNITS, 3, number of requesting execution units (1 or more).
- DATA_WIDTH, 32, result width.
- ID_WIDTH, 3, instruction ID width. The ID table has 2**ID_WIDTH entries.
- PHYS_ADDR_W, 6, physical register address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- issue_valid  in  1  write issue_phys_rd_addr into the ID table at issue_id
- issue_id  in  ID_WIDTH  ID being issued
- issue_phys_rd_addr  in  PHYS_ADDR_W  destination physical register of issued instruction
- unit_done  in  NUM_UNITS  per-unit result available
- unit_id  in  NUM_UNITS x ID_WIDTH  per-unit instruction ID
- unit_data  in  NUM_UNITS x DATA_WIDTH  per-unit result
- unit_ack  out  NUM_UNITS  one-hot grant, combinational
- commit_valid  out  1  commit packet valid
- commit_id  out  ID_WIDTH  ID of committed result
- commit_data  out  DATA_WIDTH  committed result
- wb_phys_addr  out  PHYS_ADDR_W  physical register written by this commit

Behaviour:
- Clock and reset:
  - Single clock clk; rst is synchronous and active-high.
  - Reset clears commit_valid, commit_id, commit_data, wb_phys_addr and the round-robin pointer (unit 0 highest priority).
  - The ID table is not reset; it is LUTRAM-style storage.
- Arbitration:
  - unit_ack[k]=1 iff unit_done[k]=1, k is the first requesting unit at or after the pointer (mod NUM_UNITS), and rst=0.
  - At most one ack per cycle. No ack when no unit is done.
- Handshake:
  - A unit holds unit_done/unit_id/unit_data stable until it sees unit_ack in the same cycle.
  - A done unit that is not acked keeps waiting; no result is dropped.
  - A unit may present a new result the cycle after its ack.
- Pointer update:
  - On a grant to unit k, the pointer becomes (k+1) mod NUM_UNITS on the next edge.
  - With no grant, the pointer holds.
  - With NUM_UNITS=1 the pointer is constant 0 and unit_ack=unit_done&~rst.
- Commit register (1-cycle latency):
  - On an edge where some ack was high, commit_valid<=1, commit_id<=granted unit_id, commit_data<=granted unit_data, wb_phys_addr<=table[granted unit_id].
  - Otherwise commit_valid<=0, and id/data/phys_addr hold their previous values.
  - Sustains one commit per cycle with back-to-back grants.
- ID table:
  - 2**ID_WIDTH x PHYS_ADDR_W, written on the clk edge when issue_valid=1.
  - Read is combinational by granted ID, with read-before-write semantics. An issue write to the same ID in the same cycle as its grant does not affect that commit; the old entry is used.
  - Issue writes proceed during rst.
- Reset mid-operation: any grant in the reset cycle is suppressed (acks 0). Pending units retain done and are served after reset, starting from unit 0.
- This block applies no zero-register or writeback-suppress filtering; the register file handles both.

Test Plan:
- Reset, then issue id 2→phys 0x15. Unit 1 done with id 2, data 0xDEADBEEF → unit_ack=010 the same cycle. Next cycle: commit_valid=1, commit_id=2, commit_data=0xDEADBEEF, wb_phys_addr=0x15. Following cycle: commit_valid=0.
- All three units held done continuously after reset → acks 001,010,100,001 on consecutive cycles, with four consecutive commit_valid=1 cycles carrying the matching data.
- Pointer at 1 (last grant unit 0), units 0 and 2 done → ack 100 first, then 001. Unit 0's data stays stable until its ack and commits second.
- Table has id 5→0x08. Same cycle: issue id 5→0x3F and grant of unit with id 5 → commit shows wb_phys_addr=0x08. A later grant of id 5 → 0x3F.
- rst asserted while units 0 and 1 are done → acks 000 and commit_valid=0 during reset. First post-reset cycle: ack 001.
- NUM_UNITS=1 build: done pulses on cycles 3,4,6 → acks on the same cycles, commit_valid on cycles 4,5,7.
